// File: rtl/mp_regfile.sv
// rtl/mp_regfile.sv - multi-read-port register file with write bypass and per-register busy scoreboard
module mp_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 4,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NRD*ADDR_W-1:0]  rd_addr,
  output logic [NRD*DATA_W-1:0]  rd_data,
  output logic [NRD-1:0]         rd_busy,
  input  logic                   we0,
  input  logic [ADDR_W-1:0]      wa0,
  input  logic [DATA_W-1:0]      wd0,
  input  logic                   we1,
  input  logic [ADDR_W-1:0]      wa1,
  input  logic [DATA_W-1:0]      wd1,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_addr,
  output logic [31:0]            wr_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [31:0]       wr_count_q, wr_count_d;
  logic              acc0, acc1, iss_ok;

  // A write or issue aimed at the hardwired zero register never counts.
  always_comb begin
    acc0   = we0 && !(HAS_ZERO && (wa0 == '0));
    acc1   = we1 && !(HAS_ZERO && (wa1 == '0));
    iss_ok = iss_valid && !(HAS_ZERO && (iss_addr == '0));
  end

  // Busy scoreboard next state: writes retire producers, an issue in the same cycle re-arms.
  always_comb begin
    busy_d = busy_q;
    if (acc0) busy_d[wa0] = 1'b0;
    if (acc1) busy_d[wa1] = 1'b0;
    if (iss_ok) busy_d[iss_addr] = 1'b1;
    wr_count_d = wr_count_q + {31'd0, acc0} + {31'd0, acc1};
  end

  // Register array update; port 1 is written last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      if (acc0) regs_q[wa0] <= wd0;
      if (acc1) regs_q[wa1] <= wd1;
    end
  end

  // Scoreboard and write counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q     <= '0;
      wr_count_q <= '0;
    end else begin
      busy_q     <= busy_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0, hit1;
    logic [DATA_W-1:0] data_k;
    logic              busy_k;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    // Zero-latency read: same-cycle writes bypass the array, port 1 over port 0.
    always_comb begin
      hit0 = acc0 && (wa0 == ra);
      hit1 = acc1 && (wa1 == ra);
      if (HAS_ZERO && (ra == '0)) data_k = '0;
      else if (hit1)              data_k = wd1;
      else if (hit0)              data_k = wd0;
      else                        data_k = regs_q[ra];
      busy_k = busy_q[ra] && !hit0 && !hit1;
    end

    assign rd_data[k*DATA_W +: DATA_W] = data_k;
    assign rd_busy[k]                  = busy_k;
  end

endmodule
